// File: rtl/cmac_pkg.sv
`timescale 1ns/1ps
// Shared defaults, state encoding and the saturating/wrapping add reduction
// used by the error-compensation MAC cell.
package cmac_pkg;

  localparam int W_W_DEF = 8;
  localparam int A_W_DEF = 8;
  localparam int S_W_DEF = 24;

  // Control state encoding (single bit, kept as a plain constant).
  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

  // Reduces an (width+1)-bit sum to width bits. Any set bit at or above
  // position `width` is a carry out: clamp to all-ones when saturating,
  // otherwise drop it. Handles sums up to 64 bits wide.
  function automatic logic [63:0] sat_add(input logic [64:0]  sum_ext,
                                          input int unsigned  width,
                                          input logic         saturate);
    logic [63:0] mask;
    logic        ovf;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    ovf  = |(sum_ext >> width);
    if (saturate && ovf) begin
      return mask;
    end
    return sum_ext[63:0] & mask;
  endfunction

endpackage

// File: rtl/cmac_sat_adder.sv
`timescale 1ns/1ps
// Three-operand adder: S_W-bit base plus two P_W-bit addends, evaluated at
// S_W+1 bits, then clamped or wrapped back to S_W bits. S_W >= P_W+1
// guarantees the true sum never needs more than S_W+1 bits.
module cmac_sat_adder
  import cmac_pkg::*;
#(
  parameter int S_W      = S_W_DEF,
  parameter int P_W      = W_W_DEF + A_W_DEF,
  parameter bit SATURATE = 1'b1
) (
  input  logic [S_W-1:0] a,
  input  logic [P_W-1:0] b,
  input  logic [P_W-1:0] c,
  output logic [S_W-1:0] sum
);

  logic [S_W:0] sum_ext;

  assign sum_ext = {1'b0, a} + (S_W+1)'(b) + (S_W+1)'(c);
  assign sum     = S_W'(sat_add(65'(sum_ext), S_W, SATURATE));

endmodule

// File: rtl/cmac_unit_param.sv
`timescale 1ns/1ps
// Error-compensation MAC cell for a systolic DNN column. Multiplies
// weight*activation and adds it to the incoming partial sum; when the timing
// monitor flags the product it is either deferred downstream or, in the last
// cell of a column, added one cycle later after a recovery stall.
module cmac_unit_param
  import cmac_pkg::*;
#(
  parameter int W_W      = W_W_DEF,
  parameter int A_W      = A_W_DEF,
  parameter int P_W      = W_W + A_W,
  parameter int S_W      = S_W_DEF,
  parameter bit SATURATE = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_W-1:0]   weight,
  input  logic [A_W-1:0]   activation,
  input  logic [S_W-1:0]   partial_sum_in,
  input  logic [P_W-1:0]   error_product_in,
  input  logic             timing_err,
  input  logic             last_in,
  output logic             out_valid,
  output logic [S_W-1:0]   partial_sum_out,
  output logic [P_W-1:0]   error_product_out,
  output logic [A_W-1:0]   next_activation,
  output logic             error_sig,
  output logic [P_W-1:0]   mult_out,
  output logic [CNT_W-1:0] err_count
);

  logic [0:0]     state;
  logic [S_W-1:0] base_q;
  logic [P_W-1:0] prod;
  logic           accept;
  logic [S_W-1:0] add_a;
  logic [P_W-1:0] add_b;
  logic [P_W-1:0] add_c;
  logic [S_W-1:0] add_sum;

  assign in_ready = (state == ST_RUN);
  assign accept   = in_valid && in_ready;
  assign prod     = P_W'(weight) * P_W'(activation);

  // Share one adder between the RUN sum and the RECOVER completion. In
  // RECOVER the held product is mult_out, which cannot change until the
  // next accepted beat.
  always_comb begin
    add_a = partial_sum_in;
    add_b = error_product_in;
    add_c = timing_err ? '0 : prod;
    if (state == ST_RECOVER) begin
      add_a = base_q;
      add_b = mult_out;
      add_c = '0;
    end
  end

  cmac_sat_adder #(
    .S_W      (S_W),
    .P_W      (P_W),
    .SATURATE (SATURATE)
  ) u_adder (
    .a   (add_a),
    .b   (add_b),
    .c   (add_c),
    .sum (add_sum)
  );

  // Beat acceptance, deferral / recovery sequencing and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_RUN;
      base_q            <= '0;
      out_valid         <= 1'b0;
      partial_sum_out   <= '0;
      error_product_out <= '0;
      next_activation   <= '0;
      error_sig         <= 1'b0;
      mult_out          <= '0;
      err_count         <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_RUN: begin
          if (accept) begin
            mult_out        <= prod;
            next_activation <= activation;
            if (timing_err && (err_count != '1)) begin
              err_count <= err_count + 1'b1;
            end
            if (!timing_err) begin
              partial_sum_out   <= add_sum;
              error_product_out <= '0;
              error_sig         <= 1'b0;
              out_valid         <= 1'b1;
            end else if (!last_in) begin
              partial_sum_out   <= add_sum;
              error_product_out <= prod;
              error_sig         <= 1'b1;
              out_valid         <= 1'b1;
            end else begin
              // Last cell cannot defer: keep sum(0) and finish next cycle.
              base_q <= add_sum;
              state  <= ST_RECOVER;
            end
          end
        end
        ST_RECOVER: begin
          partial_sum_out   <= add_sum;
          error_product_out <= '0;
          error_sig         <= 1'b0;
          out_valid         <= 1'b1;
          state             <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: doc/cmac_unit_param.md
Name: cmac_unit_param

Overview:
- Parametrised, handshaked successor of the default error-compensation MAC cell for low-voltage DNN accelerator columns.
- Each cycle it multiplies weight × activation and accumulates the result into the partial sum flowing down the column.
- When the external timing monitor flags the current product as unreliable, the cell defers that product to the next cell via error_product_out instead of adding it.
- If the cell is the last in its column, it cannot defer, so it self-corrects with a one-cycle recovery stall.

Parameters:
- W_W, 8, weight width (unsigned)
- A_W, 8, activation width (unsigned)
- P_W, W_W+A_W, product and error-product width
- S_W, 24, partial-sum width; must satisfy S_W ≥ P_W+1
- SATURATE, 1, 1 = clamp partial sum at 2^S_W−1; 0 = wrap modulo 2^S_W
- CNT_W, 8, width of the saturating error counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  cell can accept a beat; combinational, high iff state==RUN
- weight  in  W_W  weight operand
- activation  in  A_W  activation operand
- partial_sum_in  in  S_W  partial sum from the upstream cell
- error_product_in  in  P_W  product deferred by the upstream cell (0 if none)
- timing_err  in  1  timing monitor flag: this cycle's product is unreliable
- last_in  in  1  this cell is the last in its column; deferral is not allowed
- out_valid  out  1  output beat valid (one-cycle pulse per beat)
- partial_sum_out  out  S_W  accumulated sum to the downstream cell
- error_product_out  out  P_W  product deferred to the downstream cell
- next_activation  out  A_W  registered activation, forwarded along the row
- error_sig  out  1  this beat deferred its product
- mult_out  out  P_W  registered weight*activation
- err_count  out  CNT_W  saturating count of timing_err events accepted

Behaviour:
- Reset: every output register is cleared to 0; state=RUN; holding registers cleared.
- Reset is asynchronous. Asserting it in RECOVER discards the held beat; no out_valid pulse follows.
- A beat is accepted when in_valid && in_ready. All outputs are registered; latency is 1 cycle in RUN.
- prod = weight*activation, computed at full P_W width with no truncation.
- sum(x) = partial_sum_in + error_product_in + x, computed at S_W+1 bits.
  - SATURATE=1: if bit S_W is set, the result is 2^S_W−1.
  - SATURATE=0: bit S_W is dropped.
- RUN, accepted beat, !timing_err:
  - partial_sum_out=sum(prod); error_product_out=0; error_sig=0; out_valid=1.
- RUN, accepted beat, timing_err && !last_in:
  - partial_sum_out=sum(0); error_product_out=prod; error_sig=1; out_valid=1.
- RUN, accepted beat, timing_err && last_in:
  - Hold base=sum(0) and prod internally; go to RECOVER; out_valid=0 next cycle.
- RECOVER, one cycle, in_ready=0:
  - partial_sum_out=base+prod (same saturate/wrap rule); error_product_out=0; error_sig=0; out_valid=1; return to RUN.
  - timing_err is ignored in RECOVER: the product is stable by then.
- For every accepted beat: mult_out=prod and next_activation=activation are updated. They hold their value otherwise.
- No accepted beat: out_valid=0; all other outputs hold.
- err_count increments by 1 per accepted beat with timing_err and saturates at 2^CNT_W−1. It counts deferred and recovered beats alike.
- A nonzero error_product_in is always added, including on beats where this cell defers its own product. Only one deferred product can be in flight per hop.
- There is no downstream back-pressure: a systolic column consumes every out_valid beat.

Decomposition:
- Shared package cmac_pkg holds:
  - default widths (W_W, A_W, S_W)
  - state encoding: RUN=1'b0, RECOVER=1'b1
  - a sat_add function (S_W+1 → S_W, saturate or wrap by flag)
- One sub-module is natural: cmac_sat_adder. It is a three-operand adder with the SATURATE option and is used for both the RUN and RECOVER sums.

Test Plan:
- Clean beat: weight=0x10, act=0x02, psum=0x008000, eprod=0 → partial_sum_out=0x008020, mult_out=0x0020, error_sig=0, out_valid pulse 1 cycle later.
- Compensation: weight=0x20, act=0x03, psum=0x001000, eprod=0x0012, timing_err=0 → 0x001072, error_product_out=0.
- Defer: same operands, timing_err=1, last_in=0 → partial_sum_out=0x001012, error_product_out=0x0060, error_sig=1, err_count=1.
- Last-cell recovery: same operands, timing_err=1, last_in=1 → in_ready low 1 cycle, no out_valid on cycle+1, partial_sum_out=0x001072 with out_valid on cycle+2, then in_ready high.
- Overflow: psum=0xFFFFF0, weight=0x20, act=0x03 → 0xFFFFFF when SATURATE=1; 0x000050 when SATURATE=0.
- Reset during RECOVER → all outputs 0 immediately and no out_valid. With CNT_W=2, five timing_err beats → err_count=3.
